// File: rtl/spi_reg_config.sv
// ---------------------------------------------------------------------------
// spi_reg_config
// SPI (mode 0) write-only configuration port. Frames are 16 bits, MSB first:
//   bit15 = R/W (1 = write), bits14..8 = address, bits7..0 = data.
// Writes to addresses 0..MAX_ADDR land in five byte registers. Any other
// framed transaction is discarded and flagged on txn_err.
//
// Ports
//   clk              system clock, all logic on its rising edge
//   rst_n            asynchronous active-low reset
//   sclk, ncs, copi  raw SPI pins, asynchronous to clk
//   en_reg_out_7_0   reg 0x00  output enables 7..0
//   en_reg_out_15_8  reg 0x01  output enables 15..8
//   en_reg_pwm_7_0   reg 0x02  PWM select 7..0
//   en_reg_pwm_15_8  reg 0x03  PWM select 15..8
//   pwm_duty_cycle   reg 0x04  PWM duty
//   txn_ok           one-clk pulse when a write commits
//   txn_err          one-clk pulse when a framed transaction is discarded
// ---------------------------------------------------------------------------
module spi_reg_config #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       copi,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       txn_ok,
    output logic       txn_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        OVERRUN = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic                   sclk_dly_q;
    logic                   ncs_dly_q;
    // Fills with ones after reset; edges count only once both the last
    // synchronizer stage and the delay flop hold real pin samples, so the
    // reset value of ncs (high) cannot fake a falling edge on release.
    logic [SYNC_STAGES:0]   valid_q;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [15:0] shift_q;

    logic sclk_s, ncs_s, copi_s;
    logic edge_ok;
    logic sclk_rise, ncs_rise, ncs_fall;
    logic frame_good;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_s   = ncs_sync_q[SYNC_STAGES-1];
    assign copi_s  = copi_sync_q[SYNC_STAGES-1];
    assign edge_ok = valid_q[SYNC_STAGES];

    assign sclk_rise = edge_ok & sclk_s & ~sclk_dly_q & ~ncs_s;
    assign ncs_rise  = edge_ok & ncs_s & ~ncs_dly_q;
    assign ncs_fall  = edge_ok & ~ncs_s & ncs_dly_q;

    assign frame_good = (cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] <= MAX_ADDR);

    // NOTE: every flop in this design, synchronizers included, is assigned with
    // non-blocking (<=) so all state updates see the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '1;
            copi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            ncs_dly_q   <= 1'b1;
            valid_q     <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            sclk_dly_q  <= sclk_s;
            ncs_dly_q   <= ncs_s;
            valid_q     <= {valid_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Frame FSM with registered pulse outputs and the register file.
    // NOTE: the config registers are few and visible outputs, so they are
    // reset explicitly rather than left to power-up values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            shift_q         <= '0;
            txn_ok          <= 1'b0;
            txn_err         <= 1'b0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else begin
            txn_ok  <= 1'b0;
            txn_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ncs_fall) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        shift_q <= '0;
                    end
                end
                SHIFT: begin
                    // ncs rise has priority over a coincident sclk rise.
                    if (ncs_rise) begin
                        state_q <= IDLE;
                        if (frame_good) begin
                            txn_ok <= 1'b1;
                            case (shift_q[14:8])
                                7'h00:   en_reg_out_7_0  <= shift_q[7:0];
                                7'h01:   en_reg_out_15_8 <= shift_q[7:0];
                                7'h02:   en_reg_pwm_7_0  <= shift_q[7:0];
                                7'h03:   en_reg_pwm_15_8 <= shift_q[7:0];
                                7'h04:   pwm_duty_cycle  <= shift_q[7:0];
                                default: ;
                            endcase
                        end else if (cnt_q != 5'd0) begin
                            txn_err <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        if (cnt_q == 5'd16) begin
                            state_q <= OVERRUN;
                        end else begin
                            shift_q <= {shift_q[14:0], copi_s};
                            cnt_q   <= cnt_q + 5'd1;
                        end
                    end
                end
                OVERRUN: begin
                    if (ncs_rise) begin
                        state_q <= IDLE;
                        txn_err <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
